// File: rtl/mem_wr_queue.sv
// mem_wr_queue
//   Write-side staging queue in front of the register-file memory. Write
//   requests are accepted over a valid/ready handshake, buffered in a
//   DEPTH-entry circular queue and drained one per cycle into the memory's
//   single registered write port. A combinational lookup port lets the
//   read side forward data from writes that have not yet committed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready write request handshake
//   in_addr, in_data  write request payload
//   mem_stall         hold off issuing a write to memory this cycle
//   waddr0/we0/din0   registered memory write port
//   lk_addr           forwarding lookup address
//   lk_hit, lk_data   youngest pending write to lk_addr (data 0 on miss)
//   count, empty      queued entries, excluding the output register
module mem_wr_queue #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      mem_stall,
  output logic [ADDR_W-1:0]         waddr0,
  output logic                      we0,
  output logic [DATA_W-1:0]         din0,
  input  logic [ADDR_W-1:0]         lk_addr,
  output logic                      lk_hit,
  output logic [DATA_W-1:0]         lk_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_next;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic [PW-1:0]     lk_idx;

  // in_ready depends on registered count only, so a pop in the same cycle
  // never frees a slot for a simultaneous push.
  assign in_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !mem_stall;

  // Payload storage needs no reset; entry validity is tracked in vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= in_addr;
      data_q[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    vld_next = vld_q;
    if (pop)  vld_next[rd_ptr] = 1'b0;
    if (push) vld_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
      we0    <= 1'b0;
      waddr0 <= '0;
      din0   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      vld_q <= vld_next;
      we0   <= pop;
      if (pop) begin
        waddr0 <= addr_q[rd_ptr];
        din0   <= data_q[rd_ptr];
      end
    end
  end

  // Lookup walks from the oldest slot to the newest, letting each later
  // match overwrite the earlier one, so the youngest pending write wins.
  // The output register is the oldest candidate and is considered first.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    if (we0 && (waddr0 == lk_addr)) begin
      lk_hit  = 1'b1;
      lk_data = din0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr + PW'(i);
      if (vld_q[lk_idx] && (addr_q[lk_idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_wr_queue.sv
module tb_mem_wr_queue;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 1;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic                   mem_stall;
  logic [ADDR_W-1:0]      waddr0;
  logic                   we0;
  logic [DATA_W-1:0]      din0;
  logic [ADDR_W-1:0]      lk_addr;
  logic                   lk_hit;
  logic [DATA_W-1:0]      lk_data;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;

  mem_wr_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .mem_stall(mem_stall),
    .waddr0(waddr0), .we0(we0), .din0(din0),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .count(count), .empty(empty)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue contents, in-flight output entry, and the
  // scoreboard of writes expected to reach the memory port in order.
  ent_t m_q[$];
  ent_t exp_q[$];
  ent_t m_out = '0;
  bit   m_out_v = 0;
  bit   m_acc = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void exp_lk(input logic [ADDR_W-1:0] a, output bit h,
                                 output logic [DATA_W-1:0] d);
    h = 0;
    d = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].a == a) begin
        h = 1;
        d = m_q[i].d;
        return;
      end
    end
    if (m_out_v && m_out.a == a) begin
      h = 1;
      d = m_out.d;
    end
  endfunction

  // Model update at each edge, straight from the queue rules.
  initial begin
    bit do_pop, do_push;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        exp_q.delete();
        m_out   = '0;
        m_out_v = 0;
        m_acc   = 0;
      end else begin
        do_pop  = (m_q.size() > 0) && !mem_stall;
        do_push = in_valid && (m_q.size() < DEPTH);
        m_acc   = do_push;
        if (do_pop) begin
          m_out   = m_q.pop_front();
          m_out_v = 1;
        end else begin
          m_out_v = 0;
        end
        if (do_push) begin
          m_q.push_back('{a: in_addr, d: in_data});
          exp_q.push_back('{a: in_addr, d: in_data});
        end
      end
    end
  end

  // Cycle checker: status, output register timing and lookup.
  initial begin
    bit h;
    logic [DATA_W-1:0] d;
    #3;
    forever begin
      @(negedge clk);
      #1;
      exp_lk(lk_addr, h, d);
      check("count", count, m_q.size());
      check("in_ready", in_ready, (m_q.size() < DEPTH));
      check("empty", empty, (m_q.size() == 0));
      check("we0", we0, m_out_v);
      check("waddr0", waddr0, m_out.a);
      check("din0", din0, m_out.d);
      check("lk_hit", lk_hit, h);
      check("lk_data", lk_data, d);
    end
  end

  // Scoreboard monitor: every memory write must match the next accepted request.
  initial begin
    ent_t e;
    #3;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && we0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", waddr0, e.a);
          check("sb_data", din0, e.d);
        end
      end
    end
  end

  // Called at a falling edge; holds the request until accepted, then
  // returns at the following falling edge with the inputs still driven.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got;
    in_valid = 1;
    in_addr  = a;
    in_data  = d;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk);
      #1;
      got = m_acc;
    end
    if (!got) check("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1; in_valid = 0; in_addr = '0; in_data = '0;
    mem_stall = 0; lk_addr = '0;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_empty", empty, 1);
    @(negedge clk);

    // single request, two-cycle latency to we0
    lk_addr = 3'd5;
    send(3'd5, 1'b1);
    in_valid = 0;
    #1 check("t1_count", count, 1);
    @(negedge clk);
    #1;
    check("t1_we0", we0, 1);
    check("t1_waddr0", waddr0, 5);
    check("t1_din0", din0, 1);
    @(negedge clk);
    #1 check("t1_we0_drop", we0, 0);
    @(negedge clk);

    // fill while stalled, 5th request waits for the stall to drop
    mem_stall = 1;
    for (int i = 0; i < 4; i++) send(ADDR_W'(i), DATA_W'((i % 2 == 0) ? 1 : 0));
    #1;
    check("t2_full_ready", in_ready, 0);
    check("t2_full_count", count, 4);
    fork
      send(3'd4, 1'b1);
      begin
        repeat (3) @(negedge clk);
        mem_stall = 0;
      end
    join
    in_valid = 0;
    repeat (8) @(negedge clk);

    // youngest-first lookup
    mem_stall = 1;
    send(3'd3, 1'b1);
    send(3'd3, 1'b0);
    in_valid = 0;
    lk_addr = 3'd3;
    #2;
    check("t3_hit", lk_hit, 1);
    check("t3_data", lk_data, 0);
    lk_addr = 3'd6;
    #1;
    check("t3_miss_hit", lk_hit, 0);
    check("t3_miss_data", lk_data, 0);
    @(negedge clk);
    mem_stall = 0;
    repeat (5) @(negedge clk);

    // streaming push and pop, pointers wrap
    for (int i = 0; i < 10; i++) begin
      send(ADDR_W'($urandom), DATA_W'($urandom));
      #1 check("t4_count", count, 1);
    end
    in_valid = 0;
    repeat (4) @(negedge clk);

    // reset mid-operation
    mem_stall = 1;
    for (int i = 1; i <= 4; i++) send(ADDR_W'(i), DATA_W'($urandom));
    in_valid = 0;
    lk_addr = 3'd3;
    mem_stall = 0;
    @(negedge clk);
    mem_stall = 1;
    #1;
    check("t5_we0", we0, 1);
    check("t5_count", count, 3);
    #2 rst_n = 0;
    #1;
    check("t5_rst_we0", we0, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_lk_hit", lk_hit, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("t5_empty", empty, 1);
    check("t5_in_ready", in_ready, 1);
    @(negedge clk);

    // forwarding from the output register only
    send(3'd2, 1'b1);
    in_valid = 0;
    lk_addr = 3'd2;
    mem_stall = 0;
    @(negedge clk);
    #1;
    check("t6_we0", we0, 1);
    check("t6_waddr0", waddr0, 2);
    check("t6_empty", empty, 1);
    check("t6_hit", lk_hit, 1);
    check("t6_data", lk_data, 1);
    @(negedge clk);
    #1;
    check("t6_hit_after", lk_hit, 0);
    @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = ADDR_W'($urandom);
      in_data   = DATA_W'($urandom);
      mem_stall = ($urandom_range(0, 2) == 0);
      lk_addr   = ADDR_W'($urandom);
      @(negedge clk);
    end
    in_valid = 0;
    mem_stall = 0;
    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wr_queue.md
Name: mem_wr_queue

Overview:
- Write-side staging queue that sits directly upstream of the small register-file memory.
- Accepts write requests (addr, data) over a valid/ready handshake, buffers up to DEPTH entries, and drains them one per cycle into the memory's single write port (waddr0/we0/din0).
- Provides a combinational lookup port so the read side can forward pending, not-yet-committed write data.

Parameters:
ADDR_W, 3, width of write/lookup address
DATA_W, 1, width of write data
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  write request valid
in_ready  output  1  queue can accept a request this cycle
in_addr  input  ADDR_W  write address
in_data  input  DATA_W  write data
mem_stall  input  1  high: do not issue a write to memory this cycle
waddr0  output  ADDR_W  registered memory write address
we0  output  1  registered memory write enable
din0  output  DATA_W  registered memory write data
lk_addr  input  ADDR_W  forwarding lookup address
lk_hit  output  1  a pending write to lk_addr exists
lk_data  output  DATA_W  data of youngest pending write to lk_addr; 0 when no hit
count  output  $clog2(DEPTH)+1  entries currently queued, excluding the in-flight output register
empty  output  1  count == 0

Behaviour:
- Reset (rst_n low, asynchronous): count=0, read/write pointers=0, we0=0, waddr0=0, din0=0, all entry valid bits cleared. This gives in_ready=1, empty=1, lk_hit=0 and lk_data=0 while reset is held and on the first cycle after release.
- Reset asserted mid-operation discards all queued and in-flight writes. The we0 pulse in progress drops immediately.
- in_ready = (count < DEPTH). It is a function of registered state only and has no combinational path from mem_stall or in_valid.
- Push: in_valid && in_ready at a rising edge. Entry is written at the write pointer, the pointer increments mod DEPTH, and count increments.
- Pop: !empty && !mem_stall at a rising edge. The head entry loads into waddr0/din0 with we0=1, the read pointer increments mod DEPTH, and count decrements.
- No pop at an edge: we0=0 on the next cycle; waddr0/din0 hold their last values.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Full queue: push is impossible because in_ready=0, even if a pop occurs that edge. in_ready rises the cycle after the pop.
- Empty queue: a request pushed at edge N is popped no earlier than edge N+1. Minimum accept-to-we0 latency is therefore 2 cycles; there is no bypass from the input to the output register.
- The memory commits a write at the edge where we0=1. Ordering is strictly FIFO, and duplicate addresses are not coalesced.
- Lookup (combinational) searches all valid queue entries plus the output register when we0=1.
  - Priority is youngest first: newest queue entry, then older queue entries, then the output register.
  - A request being pushed in the current cycle is not visible until the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits. count distinguishes full from empty.

Test Plan:
1. Reset release, in_valid=1 addr=5 data=1 for one cycle, mem_stall=0 -> in_ready=1; count=1 next cycle; we0=1, waddr0=5, din0=1 exactly 2 cycles after accept, then we0=0.
2. mem_stall=1, push addr 0,1,2,3 with data 1,0,1,0 -> count reaches 4 and in_ready=0. A 5th request (addr 4) is held until mem_stall drops. Output order is 0,1,2,3,4 on consecutive cycles.
3. mem_stall=1, push (3,1) then (3,0); lk_addr=3 -> lk_hit=1, lk_data=0 (youngest wins). lk_addr=6 -> lk_hit=0, lk_data=0.
4. Continuous push and pop with mem_stall=0 for 10 requests, so pointers wrap twice -> count stays at 1 in steady state; all 10 writes appear in order with no gaps.
5. Queue holding 3 entries with we0=1; assert rst_n=0 asynchronously mid-cycle -> we0, count, lk_hit drop to 0 immediately. After release, empty=1 and in_ready=1.
6. Single entry in flight: we0=1, waddr0=2, din0=1, queue empty, lk_addr=2 -> lk_hit=1, lk_data=1. The next cycle, after the commit, lk_hit=0.
